// File: rtl/jsv_palette_mapper_if.sv
// Stream bundle for the palette mapper: iteration-count beats in, RGB pixel
// beats out. "slave" is the mapper's view, "master" is the view of the
// block that feeds iteration counts and drains pixels.
interface jsv_palette_mapper_if #(
    parameter int ITER_W = 8
);
    logic              iter_valid;
    logic              iter_ready;
    logic [ITER_W-1:0] iter_count;
    logic              iter_escaped;
    logic              iter_sof;
    logic              pix_valid;
    logic              pix_ready;
    logic [7:0]        pix_r;
    logic [7:0]        pix_g;
    logic [7:0]        pix_b;
    logic              pix_sof;

    modport slave (
        input  iter_valid, iter_count, iter_escaped, iter_sof, pix_ready,
        output iter_ready, pix_valid, pix_r, pix_g, pix_b, pix_sof
    );

    modport master (
        output iter_valid, iter_count, iter_escaped, iter_sof, pix_ready,
        input  iter_ready, pix_valid, pix_r, pix_g, pix_b, pix_sof
    );
endinterface

// File: rtl/jsv_palette_mapper.sv
// jsv_palette_mapper: maps per-pixel iteration counts to 24-bit RGB using one
// of 8 palettes. Two register stages (stage 1 = index/palette capture,
// stage 2 = RGB output registers), 1 pixel/cycle, full backpressure.
// The palette select is latched only on an accepted start-of-frame beat so a
// colour change never tears a frame.
// Optional macro JSV_PALETTE_STATS_EN adds per-frame in-set pixel statistics
// (in_set_last, frame_done).
//
// Handshake: a beat moves on a side when valid & ready are both high at a
// rising clk edge; valid, once high, holds with stable data until accepted,
// and ready may depend combinationally on the downstream pix_ready.
module jsv_palette_mapper #(
    parameter int ITER_W      = 8,
    parameter int SCALE_SHIFT = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [2:0]          color_sel,
    jsv_palette_mapper_if.slave bus
`ifdef JSV_PALETTE_STATS_EN
    ,
    output logic [31:0]         in_set_last,
    output logic [0:0]          frame_done
`endif
);
    localparam int WIDE_W = ITER_W + 8;

    // Stage 1 state
    logic       s1_valid_q, s1_valid_d;
    logic [7:0] s1_idx_q,   s1_idx_d;
    logic [7:0] s1_raw_q,   s1_raw_d;
    logic       s1_esc_q,   s1_esc_d;
    logic       s1_sof_q,   s1_sof_d;
    logic [2:0] s1_pal_q,   s1_pal_d;
    logic [2:0] active_sel_q, active_sel_d;

    // Stage 2 (output) state
    logic       pix_valid_q, pix_valid_d;
    logic [7:0] pix_r_q, pix_r_d;
    logic [7:0] pix_g_q, pix_g_d;
    logic [7:0] pix_b_q, pix_b_d;
    logic       pix_sof_q, pix_sof_d;

    logic              s1_load, s2_load, in_fire;
    logic [WIDE_W-1:0] wide_count;
    logic [7:0]        idx_sat;
    logic [2:0]        beat_pal;
    logic [7:0]        rgb_r, rgb_g, rgb_b;
    logic [8:0]        fire_dbl;

`ifdef JSV_PALETTE_STATS_EN
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] in_set_last_q, in_set_last_d;
    logic        frame_done_q, frame_done_d;
`endif

    // Pipeline advance: a stage loads when it is empty or its contents move on.
    always_comb begin
        s2_load = ~pix_valid_q | bus.pix_ready;
        s1_load = ~s1_valid_q | s2_load;
        in_fire = bus.iter_valid & s1_load;
    end

    assign bus.iter_ready = s1_load;

    // Stage 1: scaled/saturated index and the palette in force for this beat.
    always_comb begin
        wide_count   = WIDE_W'(bus.iter_count) << SCALE_SHIFT;
        idx_sat      = (wide_count > WIDE_W'(255)) ? 8'hFF : wide_count[7:0];
        // An sof beat already uses the newly selected palette.
        beat_pal     = bus.iter_sof ? color_sel : active_sel_q;

        s1_valid_d   = s1_valid_q;
        s1_idx_d     = s1_idx_q;
        s1_raw_d     = s1_raw_q;
        s1_esc_d     = s1_esc_q;
        s1_sof_d     = s1_sof_q;
        s1_pal_d     = s1_pal_q;
        active_sel_d = active_sel_q;
        if (s1_load) begin
            s1_valid_d = bus.iter_valid;
        end
        if (in_fire) begin
            s1_idx_d = idx_sat;
            s1_raw_d = bus.iter_count[7:0];
            s1_esc_d = bus.iter_escaped;
            s1_sof_d = bus.iter_sof;
            s1_pal_d = beat_pal;
            if (bus.iter_sof) begin
                active_sel_d = color_sel;
            end
        end
    end

    // Stage 2: palette lookup on the stage-1 contents.
    always_comb begin
        fire_dbl = {s1_idx_q, 1'b0};
        rgb_r    = 8'd0;
        rgb_g    = 8'd0;
        rgb_b    = 8'd0;
        if (s1_esc_q) begin
            case (s1_pal_q)
                3'd0: begin rgb_r = s1_idx_q; rgb_g = s1_idx_q; rgb_b = s1_idx_q; end
                3'd1: rgb_r = s1_idx_q;
                3'd2: rgb_g = s1_idx_q;
                3'd3: rgb_b = s1_idx_q;
                3'd4: begin
                    rgb_r = fire_dbl[8] ? 8'hFF : fire_dbl[7:0];
                    rgb_g = s1_idx_q[7] ? {s1_idx_q[6:0], 1'b0} : 8'd0;
                end
                3'd5: begin rgb_g = s1_idx_q; rgb_b = 8'hFF; end
                3'd6: begin
                    rgb_r = 8'hFF - s1_idx_q;
                    rgb_g = 8'hFF - s1_idx_q;
                    rgb_b = 8'hFF - s1_idx_q;
                end
                default: begin
                    // Banded palette works on the unscaled count bits.
                    rgb_r = {s1_raw_q[2:0], 5'b0};
                    rgb_g = {s1_raw_q[5:3], 5'b0};
                    rgb_b = {s1_raw_q[7:6], 6'b0};
                end
            endcase
        end

        pix_valid_d = pix_valid_q;
        pix_r_d     = pix_r_q;
        pix_g_d     = pix_g_q;
        pix_b_d     = pix_b_q;
        pix_sof_d   = pix_sof_q;
        if (s2_load) begin
            pix_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                pix_r_d   = rgb_r;
                pix_g_d   = rgb_g;
                pix_b_d   = rgb_b;
                pix_sof_d = s1_sof_q;
            end
        end
    end

`ifdef JSV_PALETTE_STATS_EN
    // Per-frame in-set counter; snapshot and pulse on every accepted sof beat.
    always_comb begin
        cnt_d         = cnt_q;
        in_set_last_d = in_set_last_q;
        frame_done_d  = 1'b0;
        if (in_fire) begin
            if (bus.iter_sof) begin
                in_set_last_d = cnt_q;
                cnt_d         = bus.iter_escaped ? 32'd0 : 32'd1;
                frame_done_d  = 1'b1;
            end else if (!bus.iter_escaped && cnt_q != 32'hFFFF_FFFF) begin
                cnt_d = cnt_q + 32'd1;
            end
        end
    end

    assign in_set_last = in_set_last_q;
    assign frame_done  = frame_done_q;
`endif

    // All state registers; reset drops every in-flight beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q    <= 1'b0;
            s1_idx_q      <= 8'd0;
            s1_raw_q      <= 8'd0;
            s1_esc_q      <= 1'b0;
            s1_sof_q      <= 1'b0;
            s1_pal_q      <= 3'd0;
            active_sel_q  <= 3'd0;
            pix_valid_q   <= 1'b0;
            pix_r_q       <= 8'd0;
            pix_g_q       <= 8'd0;
            pix_b_q       <= 8'd0;
            pix_sof_q     <= 1'b0;
`ifdef JSV_PALETTE_STATS_EN
            cnt_q         <= 32'd0;
            in_set_last_q <= 32'd0;
            frame_done_q  <= 1'b0;
`endif
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_idx_q      <= s1_idx_d;
            s1_raw_q      <= s1_raw_d;
            s1_esc_q      <= s1_esc_d;
            s1_sof_q      <= s1_sof_d;
            s1_pal_q      <= s1_pal_d;
            active_sel_q  <= active_sel_d;
            pix_valid_q   <= pix_valid_d;
            pix_r_q       <= pix_r_d;
            pix_g_q       <= pix_g_d;
            pix_b_q       <= pix_b_d;
            pix_sof_q     <= pix_sof_d;
`ifdef JSV_PALETTE_STATS_EN
            cnt_q         <= cnt_d;
            in_set_last_q <= in_set_last_d;
            frame_done_q  <= frame_done_d;
`endif
        end
    end

    assign bus.pix_valid = pix_valid_q;
    assign bus.pix_r     = pix_r_q;
    assign bus.pix_g     = pix_g_q;
    assign bus.pix_b     = pix_b_q;
    assign bus.pix_sof   = pix_sof_q;
endmodule
